uart_mmio: RTL
==============

// Module: uart_mmio
// PURPOSE
//   Memory-mapped 8N1 UART on the core's data-memory port. Sits beside
//   RAM_Simple downstream of Core: consumes io_dmem_addr/op/mask/wdata and
//   returns io_dmem_rdata combinationally, so lw/sw from the single-cycle core
//   complete in one cycle. TX side is buffered by a FIFO; RX side uses a
//   one-byte holding register with overrun and framing flags.
// PARAMETERS
//   CLOCK_FREQ   100_000_000  core clock in Hz
//   BAUD_RATE    115_200      line rate; CLKS_PER_BIT = CLOCK_FREQ/BAUD_RATE (>=4)
//   TX_DEPTH     8            TX FIFO entries, power of two
// PORTS
//   clk      in   1   core clock
//   rst      in   1   synchronous reset, active-high
//   sel      in   1   address decoded to this block (from the top-level decoder)
//   addr     in   4   byte offset, addr[3:2] selects register; addr[1:0] ignored
//   op       in   1   1 = write (store), 0 = read (load)
//   mask     in   4   byte-enables for writes
//   wdata    in   32  store data
//   rdata    out  32  load data, combinational
//   uart_tx  out  1   serial out, idle high
//   uart_rx  in   1   serial in, asynchronous
// BEHAVIOUR
//   Register map (word offset):
//   0x0 TXDATA: write with mask[0]=1 pushes wdata[7:0]; reads 0.
//   0x4 RXDATA: read returns {23'b0, rx_valid, rx_byte}; the read pops (clears
//       rx_valid at the clock edge).
//   0x8 STATUS (RO): bit0 tx_full, bit1 tx_empty, bit2 rx_valid,
//       bit3 rx_overrun, bit4 tx_busy, bit5 rx_frame_err; other bits 0.
//   0xC CTRL: write with mask[0]=1 and wdata[0]=1 clears overrun and frame_err;
//       reads 0.
//   - Side effects only when sel=1; rdata = 0 when sel=0 or op=1.
//   - Reset: uart_tx=1, FIFO empty, TX FSM IDLE, RX FSM IDLE, rx_valid=0,
//     all flags 0, baud counters 0. Reset mid-frame aborts immediately;
//     uart_tx is high on the first cycle after reset.
//   - TX FIFO: the push is dropped when tx_full is sampled at that edge, even if
//     the TX FSM pops in the same cycle. Pointers wrap modulo TX_DEPTH; count is
//     $clog2(TX_DEPTH)+1 bits.
//   - TX FSM IDLE->START->DATA->STOP->IDLE. In IDLE with FIFO non-empty: pop,
//     go to START next cycle, drive 0 for CLKS_PER_BIT cycles. Then 8 data bits
//     LSB first, then 1 stop bit (1), each CLKS_PER_BIT cycles. STOP with FIFO
//     non-empty goes directly to START (back-to-back frames, no idle gap).
//     tx_busy = (state != IDLE).
//   - RX input: 2-flop synchroniser. IDLE: on a synced 1->0 edge, go to START
//     and wait CLKS_PER_BIT/2 cycles. If still 0, go to DATA; else return to
//     IDLE (glitch). DATA: sample 8 bits at CLKS_PER_BIT intervals, LSB first.
//     STOP: sample once.
//       Stop=1: load rx_byte and set rx_valid. If rx_valid was already 1 and
//       was not popped this cycle, set rx_overrun and overwrite the byte.
//       Stop=0: discard the byte, set rx_frame_err.
//     In both cases return to IDLE.
//   - RXDATA pop and byte completion in the same cycle: the new byte is loaded,
//     rx_valid stays 1, no overrun.
//   - Writes to unmapped bytes (mask[0]=0) have no effect.
// TESTING  (CLOCK_FREQ=40, BAUD_RATE=4 -> 10 clk/bit)
//   Reset: after rst, uart_tx=1 and STATUS reads 0x02 (tx_empty only).
//   TX frame: sw 0xA5 to 0x0 -> uart_tx low for 10 clks, then bits 1,0,1,0,0,1,0,1
//     at 10 clks each, then high; tx_busy=1 for 100 clks.
//   FIFO full: 9 consecutive sw to TXDATA (0x01..0x09) -> after the 1st byte is
//     popped, pushes 2..9 fill the FIFO; tx_full=1; exactly 9 frames go out,
//     in order, back-to-back.
//   RX: drive frame 0x3C on uart_rx -> rx_valid=1; lw 0x4 returns 0x13C; the
//     next lw 0x4 returns 0x03C.
//   Overrun/framing: two frames with no read -> overrun=1, RXDATA=2nd byte.
//     Frame with stop=0 -> frame_err=1, rx_valid unchanged. sw 1 to 0xC -> both
//     flags clear.
//   Glitch/reset: 3-clk low pulse on uart_rx -> no byte, no flags. rst asserted
//     mid-TX -> uart_tx=1 next cycle, FIFO empty.

Source files
------------

// File: rtl/uart_mmio.sv
// uart_mmio: memory-mapped 8N1 UART for the core data-memory port.
// It has a buffered TX path (FIFO + serialiser) and an RX path
// (synchroniser, deserialiser and a one-byte holding register with flags).
// Loads return data combinationally, so single-cycle lw/sw complete in one cycle.
module uart_mmio #(
  parameter int unsigned CLOCK_FREQ = 100_000_000,
  parameter int unsigned BAUD_RATE  = 115_200,
  parameter int unsigned TX_DEPTH   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sel,
  input  logic [3:0]  addr,
  input  logic        op,
  input  logic [3:0]  mask,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        uart_tx,
  input  logic        uart_rx
);

  localparam int unsigned CLKS_PER_BIT = CLOCK_FREQ / BAUD_RATE;
  localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT);
  localparam int unsigned PTR_W        = $clog2(TX_DEPTH);

  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [PTR_W:0]   FIFO_FULL = (PTR_W + 1)'(TX_DEPTH);

  localparam logic [1:0] TX_IDLE  = 2'd0;
  localparam logic [1:0] TX_START = 2'd1;
  localparam logic [1:0] TX_DATA  = 2'd2;
  localparam logic [1:0] TX_STOP  = 2'd3;

  localparam logic [1:0] RX_IDLE  = 2'd0;
  localparam logic [1:0] RX_START = 2'd1;
  localparam logic [1:0] RX_DATA  = 2'd2;
  localparam logic [1:0] RX_STOP  = 2'd3;

  // Register decode
  logic [1:0] reg_idx;
  logic       wr_en, rd_en, push_req, rx_pop, flag_clr;

  assign reg_idx  = addr[3:2];
  assign wr_en    = sel && op;
  assign rd_en    = sel && !op;
  assign push_req = wr_en && (reg_idx == 2'd0) && mask[0];
  assign rx_pop   = rd_en && (reg_idx == 2'd1);
  assign flag_clr = wr_en && (reg_idx == 2'd3) && mask[0] && wdata[0];

  // Byte lanes and offset bits the register map never looks at
  logic unused_bits;
  assign unused_bits = ^{addr[1:0], mask[3:1], wdata[31:8]};

  // TX FIFO
  logic [7:0]       fifo_mem [TX_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   fifo_cnt;
  logic             tx_full, tx_empty, push_ok, tx_pop;

  // TX serialiser
  logic [1:0]       tx_state;
  logic [CNT_W-1:0] tx_cnt;
  logic [2:0]       tx_bit;
  logic [7:0]       tx_shift;
  logic             tx_busy, tx_bit_end;

  assign tx_full    = (fifo_cnt == FIFO_FULL);
  assign tx_empty   = (fifo_cnt == '0);
  assign push_ok    = push_req && !tx_full;
  assign tx_bit_end = (tx_cnt == BIT_LAST);
  // The FIFO is popped from IDLE, or at the end of STOP so frames run back-to-back
  assign tx_pop     = !tx_empty &&
                      ((tx_state == TX_IDLE) || ((tx_state == TX_STOP) && tx_bit_end));
  assign tx_busy    = (tx_state != TX_IDLE);

  // FIFO storage: written on accepted pushes only
  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem[wr_ptr] <= wdata[7:0];
  end

  // FIFO pointers and occupancy; full is judged before any same-cycle pop
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (tx_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_ok, tx_pop})
        2'b10:   fifo_cnt <= fifo_cnt + (PTR_W + 1)'(1);
        2'b01:   fifo_cnt <= fifo_cnt - (PTR_W + 1)'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // TX state machine: start bit, 8 data bits LSB first, stop bit
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
    end else begin
      case (tx_state)
        TX_IDLE: begin
          if (tx_pop) begin
            tx_shift <= fifo_mem[rd_ptr];
            tx_cnt   <= '0;
            tx_state <= TX_START;
          end
        end
        TX_START: begin
          if (tx_bit_end) begin
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_state <= TX_DATA;
          end else begin
            tx_cnt <= tx_cnt + CNT_W'(1);
          end
        end
        TX_DATA: begin
          if (tx_bit_end) begin
            tx_cnt <= '0;
            if (tx_bit == 3'd7) begin
              tx_state <= TX_STOP;
            end else begin
              tx_bit   <= tx_bit + 3'd1;
              tx_shift <= {1'b0, tx_shift[7:1]};
            end
          end else begin
            tx_cnt <= tx_cnt + CNT_W'(1);
          end
        end
        TX_STOP: begin
          if (tx_bit_end) begin
            tx_cnt <= '0;
            if (tx_pop) begin
              tx_shift <= fifo_mem[rd_ptr];
              tx_state <= TX_START;
            end else begin
              tx_state <= TX_IDLE;
            end
          end else begin
            tx_cnt <= tx_cnt + CNT_W'(1);
          end
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

  // Serial line level is a pure function of the TX state, so reset forces it high at once
  always_comb begin
    case (tx_state)
      TX_START: uart_tx = 1'b0;
      TX_DATA:  uart_tx = tx_shift[0];
      default:  uart_tx = 1'b1;
    endcase
  end

  // RX path
  logic             rx_s1, rx_s2, rx_s3;
  logic [1:0]       rx_state;
  logic [CNT_W-1:0] rx_cnt;
  logic [2:0]       rx_bit;
  logic [7:0]       rx_shift, rx_byte;
  logic             rx_valid, rx_overrun, rx_frame_err;

  // Two-flop synchroniser plus one delayed copy for falling-edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      rx_s3 <= 1'b1;
    end else begin
      rx_s1 <= uart_rx;
      rx_s2 <= rx_s1;
      rx_s3 <= rx_s2;
    end
  end

  // RX state machine and holding register; a completing byte overrides a same-cycle pop
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state     <= RX_IDLE;
      rx_cnt       <= '0;
      rx_bit       <= '0;
      rx_shift     <= '0;
      rx_byte      <= '0;
      rx_valid     <= 1'b0;
      rx_overrun   <= 1'b0;
      rx_frame_err <= 1'b0;
    end else begin
      if (rx_pop) rx_valid <= 1'b0;
      if (flag_clr) begin
        rx_overrun   <= 1'b0;
        rx_frame_err <= 1'b0;
      end
      case (rx_state)
        RX_IDLE: begin
          if (rx_s3 && !rx_s2) begin
            rx_cnt   <= '0;
            rx_state <= RX_START;
          end
        end
        RX_START: begin
          if (rx_cnt == HALF_LAST) begin
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_state <= rx_s2 ? RX_IDLE : RX_DATA;
          end else begin
            rx_cnt <= rx_cnt + CNT_W'(1);
          end
        end
        RX_DATA: begin
          if (rx_cnt == BIT_LAST) begin
            rx_cnt   <= '0;
            rx_shift <= {rx_s2, rx_shift[7:1]};
            if (rx_bit == 3'd7) rx_state <= RX_STOP;
            else                rx_bit   <= rx_bit + 3'd1;
          end else begin
            rx_cnt <= rx_cnt + CNT_W'(1);
          end
        end
        RX_STOP: begin
          if (rx_cnt == BIT_LAST) begin
            rx_cnt   <= '0;
            rx_state <= RX_IDLE;
            if (rx_s2) begin
              rx_byte  <= rx_shift;
              rx_valid <= 1'b1;
              if (rx_valid && !rx_pop) rx_overrun <= 1'b1;
            end else begin
              rx_frame_err <= 1'b1;
            end
          end else begin
            rx_cnt <= rx_cnt + CNT_W'(1);
          end
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  // Combinational load data
  always_comb begin
    rdata = '0;
    if (rd_en) begin
      case (reg_idx)
        2'd1:    rdata = {23'b0, rx_valid, rx_byte};
        2'd2:    rdata = {26'b0, rx_frame_err, tx_busy, rx_overrun, rx_valid, tx_empty, tx_full};
        default: rdata = '0;
      endcase
    end
  end

endmodule
